// File: rtl/rf_pkg.sv
// Shared register-file constants for the write-back path.
package rf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Register 0 is hard-wired; writes to it are dropped at the output stage.
    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches req upward from rr_ptr (wrapping) and grants the
// first set bit. rr_ptr moves one past the winner whenever the caller signals advance.
module rr_arbiter #(
    parameter int unsigned NREQ = 3
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned     ptr_ext;
    logic [NREQ-1:0] req_rot;
    logic [NREQ-1:0] gnt_rot;
    logic [NREQ:0][PtrW-1:0] idx_acc;
    logic [PtrW-1:0] win_idx;

    assign ptr_ext = 32'(rr_ptr_q);

    // Rotate so the requester at rr_ptr sits at bit 0, isolate the lowest set bit,
    // then rotate the one-hot back into requester order.
    assign req_rot = NREQ'({req, req} >> ptr_ext);
    assign gnt_rot = req_rot & (~req_rot + NREQ'(1));
    assign gnt     = NREQ'({gnt_rot, gnt_rot} >> (NREQ - ptr_ext));

    // One-hot to binary encode of the winner.
    assign idx_acc[0] = '0;
    for (genvar g = 0; g < NREQ; g++) begin : g_enc
        assign idx_acc[g+1] = idx_acc[g] | (gnt[g] ? PtrW'(g) : '0);
    end
    assign win_idx = idx_acc[NREQ];

    // Next pointer: one past the winner, wrapping at NREQ-1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (win_idx == PtrW'(NREQ - 1)) ? '0 : win_idx + PtrW'(1);
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: NREQ write-back sources share one write port
// through a round-robin grant and a registered output stage. Writes to register 0
// are consumed but never enabled. Optional lost-arbitration counter is built only
// when RFWB_STALL_CNT_EN is defined; otherwise stall_cnt is tied to zero.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   wb_hold,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic                   Write_Reg,
    output logic [ADDR_W-1:0]      W_Addr,
    output logic [DATA_W-1:0]      W_Data,
    output logic                   wr_pending,
    output logic [15:0]            stall_cnt
);

    logic [NREQ-1:0] req_eligible;
    logic            xfer;
    logic [NREQ:0][ADDR_W-1:0] addr_acc;
    logic [NREQ:0][DATA_W-1:0] data_acc;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              write_reg_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [DATA_W-1:0] w_data_q;

    // Freeze and reset both hide every request so gnt is forced to zero.
    assign req_eligible = (Reset || wb_hold) ? '0 : req;
    assign xfer         = |gnt;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .Reset   (Reset),
        .req     (req_eligible),
        .advance (xfer),
        .gnt     (gnt)
    );

    // AND-OR mux of the granted requester's address and data (gnt is one-hot).
    assign addr_acc[0] = '0;
    assign data_acc[0] = '0;
    for (genvar g = 0; g < NREQ; g++) begin : g_mux
        assign addr_acc[g+1] = addr_acc[g] | ({ADDR_W{gnt[g]}} & req_addr[g*ADDR_W +: ADDR_W]);
        assign data_acc[g+1] = data_acc[g] | ({DATA_W{gnt[g]}} & req_data[g*DATA_W +: DATA_W]);
    end
    assign sel_addr = addr_acc[NREQ];
    assign sel_data = data_acc[NREQ];

    // Output stage: capture the winner; address 0 is consumed without a write.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            write_reg_q <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            write_reg_q <= xfer && (sel_addr != ADDR_W'(rf_pkg::REG_ZERO));
            if (xfer) begin
                w_addr_q <= sel_addr;
                w_data_q <= sel_data;
            end
        end
    end

    assign Write_Reg  = write_reg_q;
    assign W_Addr     = w_addr_q;
    assign W_Data     = w_data_q;
    assign wr_pending = write_reg_q;

`ifdef RFWB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Count cycles in which some requester is left waiting; saturate at all-ones.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (((req & ~gnt) != '0) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'h0;
`endif

    // Grant must be at most one-hot and only to a live requester.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (Reset) $onehot0(gnt));
    a_gnt_in_req : assert property (@(posedge clk) disable iff (Reset) (gnt & ~req) == '0);

endmodule
